// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame sequencer: FSM encoding and default timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Default timings assume a 60 MHz clk_i: 1.25us bit slot, 0.4us/0.8us high times, 300us latch.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int unsigned DEF_MAX_LEDS = 256;
  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_TBIT_CYC = 75;
  localparam int unsigned DEF_T0H_CYC  = 24;
  localparam int unsigned DEF_T1H_CYC  = 48;
  localparam int unsigned DEF_TRST_CYC = 18000;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Turns one data bit into a WS2812 bit slot: high for T1H/T0H cycles, then low to TBIT_CYC total.
// Latency: led_o rises the cycle after bit_stb_i; bit_done_o marks the last cycle of the slot.
// Backpressure: none; a strobe in the bit_done_o cycle starts the next slot with no gap.
// Ports: bit_stb_i/bit_i start a slot, clr_i kills the slot and drops the line, led_o is registered.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int unsigned TBIT_CYC = DEF_TBIT_CYC,
  parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC  = DEF_T1H_CYC
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic bit_stb_i,
  input  logic bit_i,
  input  logic clr_i,
  output logic led_o,
  output logic bit_done_o
);

  localparam int unsigned CNT_W = $clog2(TBIT_CYC);

  logic             r_active;
  logic             r_bit;
  logic             r_led;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hi;

  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_hi       = r_bit ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
  assign bit_done_o = r_active && (r_cnt == CNT_W'(TBIT_CYC - 1));
  assign led_o      = r_led;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_active <= 1'b0;
      r_bit    <= 1'b0;
      r_led    <= 1'b0;
      r_cnt    <= '0;
    end else if (clr_i) begin
      r_active <= 1'b0;
      r_led    <= 1'b0;
      r_cnt    <= '0;
    end else if (bit_stb_i) begin
      r_active <= 1'b1;
      r_bit    <= bit_i;
      r_led    <= 1'b1;
      r_cnt    <= '0;
    end else if (r_active) begin
      if (bit_done_o) begin
        r_active <= 1'b0;
        r_led    <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
        // Registered pin: decide next cycle's level from the next count value.
        r_led <= (w_cnt_nxt < w_hi);
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Sequences one WS2812 frame: fetch N GRB words from pixel RAM, shift them out MSB-first, then latch low.
// Latency: read strobe 1 cycle after start, line high 3 cycles after start; pixels back-to-back.
// Backpressure: none; start_i while busy is dropped, abort_i only acts in FETCH/SHIFT.
// Ports: start/abort/num_leds from the register block, pix_rd/addr/data to the RAM, led_ctl_o to the pin.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int unsigned MAX_LEDS = DEF_MAX_LEDS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned TBIT_CYC = DEF_TBIT_CYC,
  parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC  = DEF_T1H_CYC,
  parameter int unsigned TRST_CYC = DEF_TRST_CYC
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W:0]   num_leds_i,
  output logic              pix_rd_o,
  output logic [ADDR_W-1:0] pix_addr_o,
  input  logic [23:0]       pix_data_i,
  output logic              led_ctl_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned     CYC_W = $clog2(TRST_CYC + 1);
  localparam logic [ADDR_W:0] MAX_N = (ADDR_W + 1)'(MAX_LEDS);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_idx;
  logic [4:0]        r_bit_idx;
  logic [23:0]       r_shift;
  logic [23:0]       r_next;
  logic              r_rd;
  logic              r_rd_q;
  logic [ADDR_W-1:0] r_addr;
  logic [CYC_W-1:0]  r_cyc;
  logic              r_busy;
  logic              r_done;

  logic w_accept, w_zero, w_load_first, w_advance, w_load_next;
  logic w_issue_rd, w_enter_latch, w_finish;
  logic w_bit_stb, w_bit_val, w_enc_clr, w_bit_done, w_led;

  ws2812_bit_encoder #(
    .TBIT_CYC (TBIT_CYC),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC)
  ) u_enc (
    .clk_i      (clk_i),
    .resetn_i   (resetn_i),
    .bit_stb_i  (w_bit_stb),
    .bit_i      (w_bit_val),
    .clr_i      (w_enc_clr),
    .led_o      (w_led),
    .bit_done_o (w_bit_done)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_zero        = 1'b0;
    w_load_first  = 1'b0;
    w_advance     = 1'b0;
    w_load_next   = 1'b0;
    w_issue_rd    = 1'b0;
    w_enter_latch = 1'b0;
    w_finish      = 1'b0;
    w_bit_stb     = 1'b0;
    w_bit_val     = 1'b0;
    w_enc_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (num_leds_i == '0) begin
            w_zero = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (abort_i) begin
          w_enc_clr     = 1'b1;
          w_enter_latch = 1'b1;
          w_state_nxt   = ST_LATCH;
        end else if (r_rd_q) begin
          // RAM data is valid this cycle only: load it and launch bit 23 together.
          w_load_first = 1'b1;
          w_bit_stb    = 1'b1;
          w_bit_val    = pix_data_i[23];
          w_state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort_i) begin
          w_enc_clr     = 1'b1;
          w_enter_latch = 1'b1;
          w_state_nxt   = ST_LATCH;
        end else if (w_bit_done) begin
          if (r_bit_idx == 5'd0) begin
            if (r_idx == r_n - 1'b1) begin
              w_enter_latch = 1'b1;
              w_state_nxt   = ST_LATCH;
            end else begin
              w_load_next = 1'b1;
              w_bit_stb   = 1'b1;
              w_bit_val   = r_next[23];
            end
          end else begin
            w_advance = 1'b1;
            w_bit_stb = 1'b1;
            w_bit_val = r_shift[22];
            // Prefetch the following pixel while its predecessor's bit 0 is on the wire.
            if ((r_bit_idx == 5'd1) && ((r_idx + 1'b1) < r_n)) w_issue_rd = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (r_cyc == CYC_W'(TRST_CYC - 1)) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_n       <= '0;
      r_idx     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_next    <= '0;
      r_rd      <= 1'b0;
      r_rd_q    <= 1'b0;
      r_addr    <= '0;
      r_cyc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd   <= w_accept | w_issue_rd;
      r_rd_q <= r_rd;
      r_done <= w_zero | w_finish;
      if (w_accept) begin
        r_n    <= (num_leds_i > MAX_N) ? MAX_N : num_leds_i;
        r_idx  <= '0;
        r_addr <= '0;
        r_busy <= 1'b1;
      end
      if (w_issue_rd) r_addr <= r_idx[ADDR_W-1:0] + 1'b1;
      if (r_rd_q && (r_state == ST_SHIFT)) r_next <= pix_data_i;
      if (w_load_first) begin
        r_shift   <= pix_data_i;
        r_bit_idx <= 5'd23;
      end
      if (w_advance) begin
        r_shift   <= {r_shift[22:0], 1'b0};
        r_bit_idx <= r_bit_idx - 1'b1;
      end
      if (w_load_next) begin
        r_shift   <= r_next;
        r_bit_idx <= 5'd23;
        r_idx     <= r_idx + 1'b1;
      end
      if (w_enter_latch)            r_cyc <= '0;
      else if (r_state == ST_LATCH) r_cyc <= r_cyc + 1'b1;
      if (w_finish) r_busy <= 1'b0;
    end
  end

  assign pix_rd_o   = r_rd;
  assign pix_addr_o = r_addr;
  assign led_ctl_o  = w_led;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Self-checking bench for ws2812_frame_sequencer: scoreboard of expected bits and RAM addresses.
// Bit timing kept at 75/24/48; latch period and frame size scaled down to keep runs short.
// A negedge monitor decodes the pin and read port and pops the expected queues.
module tb_ws2812_frame_sequencer;

  localparam int TBIT = 75;
  localparam int T0H  = 24;
  localparam int T1H  = 48;
  localparam int TRST = 600;
  localparam int MAXL = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          resetn_i = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW:0]   num_leds_i = '0;
  logic          pix_rd_o;
  logic [AW-1:0] pix_addr_o;
  logic [23:0]   pix_data_i = '0;
  logic          led_ctl_o, busy_o, done_o;

  logic [23:0] mem [0:MAXL-1];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_bits [$];
  logic [31:0] exp_addr [$];

  // monitor state (written only by the monitor)
  logic prev_led = 1'b0, prev_rd = 1'b0, inframe = 1'b0;
  int   since_rise = 0, hi_len = 0, rise_cnt = 0, rd_cnt = 0, done_cnt = 0, gap_at_done = 0;
  int   last_addr = 0;
  // rise index whose bit is cut short on purpose (written only by the test)
  int   skip_rise = 0;

  ws2812_frame_sequencer #(
    .MAX_LEDS (MAXL), .ADDR_W (AW), .TBIT_CYC (TBIT),
    .T0H_CYC  (T0H),  .T1H_CYC (T1H), .TRST_CYC (TRST)
  ) dut (
    .clk_i      (clk),
    .resetn_i   (resetn_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .num_leds_i (num_leds_i),
    .pix_rd_o   (pix_rd_o),
    .pix_addr_o (pix_addr_o),
    .pix_data_i (pix_data_i),
    .led_ctl_o  (led_ctl_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Pixel RAM: data valid only in the cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (pix_rd_o) pix_data_i <= mem[pix_addr_o];
    else          pix_data_i <= 24'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn_i) begin
      prev_led = 1'b0;
      prev_rd  = 1'b0;
      inframe  = 1'b0;
      hi_len   = 0;
    end else begin
      if (pix_rd_o) begin
        rd_cnt++;
        last_addr = int'(pix_addr_o);
        chk("rd_single_cycle", 32'(prev_rd), 32'd0);
        if (exp_addr.size() == 0) chk("rd_unexpected", 32'(exp_addr.size()), 32'd1);
        else                      chk("rd_addr", 32'(pix_addr_o), exp_addr.pop_front());
      end
      prev_rd = pix_rd_o;
      if (led_ctl_o && !prev_led) begin
        if (inframe) chk("bit_period", 32'(since_rise), 32'(TBIT));
        inframe    = 1'b1;
        since_rise = 1;
        hi_len     = 1;
        rise_cnt++;
      end else begin
        since_rise++;
        if (led_ctl_o) hi_len++;
        else if (prev_led && (rise_cnt != skip_rise)) begin
          logic [31:0] dec;
          dec = (hi_len == T1H) ? 32'd1 : ((hi_len == T0H) ? 32'd0 : 32'd2);
          if (exp_bits.size() == 0) chk("bit_unexpected", 32'(exp_bits.size()), 32'd1);
          else                      chk("bit_value", dec, exp_bits.pop_front());
        end
      end
      prev_led = led_ctl_o;
      if (done_o) begin
        gap_at_done = since_rise;
        inframe     = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) exp_bits.push_back(32'(w[i]));
  endtask

  task automatic load_frame(input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(32'(i));
      push_word(mem[i]);
    end
  endtask

  task automatic start_frame(input int n);
    start_i    = 1'b1;
    num_leds_i = (AW + 1)'(n);
    cyc();
    start_i    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int waited);
    waited = 0;
    while (!done_o && waited < budget) begin
      cyc();
      waited++;
    end
    chk("done_seen", 32'(done_o), 32'd1);
  endtask

  task automatic wait_rises(input int target, input int budget);
    int w = 0;
    while (rise_cnt < target && w < budget) begin
      cyc();
      w++;
    end
    chk("rise_reached", 32'(rise_cnt >= target), 32'd1);
  endtask

  initial begin
    int w, r0, d0, rd0;

    // ---- reset state ----
    cyc();
    chk("rst_led", 32'(led_ctl_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_rd", 32'(pix_rd_o), 32'd0);
    cyc();
    resetn_i = 1'b1;
    cyc();

    // ---- 1: single pixel 0xFF0000 ----
    mem[0] = 24'hFF0000;
    load_frame(1);
    r0 = rise_cnt; d0 = done_cnt;
    start_frame(1);
    chk("t1_busy_n1", 32'(busy_o), 32'd1);
    chk("t1_rd_n1", 32'(pix_rd_o), 32'd1);
    chk("t1_addr_n1", 32'(pix_addr_o), 32'd0);
    cyc();
    chk("t1_led_n2", 32'(led_ctl_o), 32'd0);
    cyc();
    chk("t1_led_n3", 32'(led_ctl_o), 32'd1);
    repeat (600) cyc();
    chk("t1_busy_mid", 32'(busy_o), 32'd1);
    wait_done(24 * TBIT + TRST + 50, w);
    chk("t1_busy_at_done", 32'(busy_o), 32'd0);
    chk("t1_latch_gap", 32'(gap_at_done), 32'(TBIT + TRST + 1));
    chk("t1_bits", 32'(rise_cnt - r0), 32'd24);
    cyc();
    chk("t1_done_pulse", 32'(done_o), 32'd0);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_q_empty", 32'(exp_bits.size() + exp_addr.size()), 32'd0);

    // ---- 2: three pixels, contiguous ----
    mem[0] = 24'hAAAAAA; mem[1] = 24'h000001; mem[2] = 24'h800000;
    load_frame(3);
    r0 = rise_cnt; rd0 = rd_cnt;
    start_frame(3);
    wait_done(72 * TBIT + TRST + 50, w);
    chk("t2_bits", 32'(rise_cnt - r0), 32'd72);
    chk("t2_reads", 32'(rd_cnt - rd0), 32'd3);
    chk("t2_latch_gap", 32'(gap_at_done), 32'(TBIT + TRST + 1));
    chk("t2_q_empty", 32'(exp_bits.size() + exp_addr.size()), 32'd0);
    cyc();

    // ---- 3a: zero-length frame ----
    r0 = rise_cnt; rd0 = rd_cnt;
    start_frame(0);
    chk("t3_done_n1", 32'(done_o), 32'd1);
    chk("t3_busy_n1", 32'(busy_o), 32'd0);
    repeat (10) cyc();
    chk("t3_no_read", 32'(rd_cnt - rd0), 32'd0);
    chk("t3_no_wave", 32'(rise_cnt - r0), 32'd0);

    // ---- 3b: clamp 12 -> MAXL ----
    for (int i = 0; i < MAXL; i++) mem[i] = 24'($urandom);
    load_frame(MAXL);
    r0 = rise_cnt; rd0 = rd_cnt;
    start_frame(12);
    wait_done(MAXL * 24 * TBIT + TRST + 50, w);
    chk("t3_clamp_reads", 32'(rd_cnt - rd0), 32'(MAXL));
    chk("t3_clamp_last", 32'(last_addr), 32'(MAXL - 1));
    chk("t3_clamp_bits", 32'(rise_cnt - r0), 32'(MAXL * 24));
    chk("t3_q_empty", 32'(exp_bits.size() + exp_addr.size()), 32'd0);
    cyc();

    // ---- 4: abort in bit 10 of pixel 1 (n=4) ----
    mem[0] = 24'h123456; mem[1] = 24'hFFFFFF; mem[2] = 24'h0F0F0F; mem[3] = 24'h555555;
    for (int i = 0; i < 4; i++) push_word(mem[i]);
    exp_addr.push_back(32'd0);
    exp_addr.push_back(32'd1);
    r0 = rise_cnt; rd0 = rd_cnt; d0 = done_cnt;
    start_frame(4);
    wait_rises(r0 + 38, 40 * TBIT);
    repeat (10) cyc();
    skip_rise = r0 + 38;
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    chk("t4_led_low", 32'(led_ctl_o), 32'd0);
    wait_done(TRST + 50, w);
    chk("t4_latch_len", 32'(w), 32'(TRST));
    chk("t4_bits", 32'(rise_cnt - r0), 32'd38);
    chk("t4_reads", 32'(rd_cnt - rd0), 32'd2);
    chk("t4_bits_left", 32'(exp_bits.size()), 32'(96 - 38 + 1));
    chk("t4_addr_left", 32'(exp_addr.size()), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
    exp_bits.delete();
    cyc();

    // ---- 5: start while busy is ignored ----
    mem[0] = 24'hC3A501; mem[1] = 24'h7E0081;
    load_frame(2);
    r0 = rise_cnt; rd0 = rd_cnt;
    start_frame(2);
    wait_rises(r0 + 30, 32 * TBIT);
    start_frame(5);
    wait_done(48 * TBIT + TRST + 50, w);
    chk("t5_bits", 32'(rise_cnt - r0), 32'd48);
    chk("t5_reads", 32'(rd_cnt - rd0), 32'd2);
    chk("t5_q_empty", 32'(exp_bits.size() + exp_addr.size()), 32'd0);
    cyc();

    // ---- 6: async reset during a high phase, then a clean frame ----
    mem[0] = 24'hFFFFFF; mem[1] = 24'h000000;
    load_frame(2);
    r0 = rise_cnt;
    start_frame(2);
    wait_rises(r0 + 5, 8 * TBIT);
    repeat (10) cyc();
    resetn_i = 1'b0;
    #1;
    chk("t6_led_rst", 32'(led_ctl_o), 32'd0);
    chk("t6_busy_rst", 32'(busy_o), 32'd0);
    exp_bits.delete();
    exp_addr.delete();
    cyc();
    cyc();
    resetn_i = 1'b1;
    cyc();
    mem[0] = 24'h00FF3C;
    load_frame(1);
    r0 = rise_cnt; d0 = done_cnt;
    start_frame(1);
    chk("t6_rd_n1", 32'(pix_rd_o), 32'd1);
    chk("t6_addr_n1", 32'(pix_addr_o), 32'd0);
    wait_done(24 * TBIT + TRST + 50, w);
    chk("t6_bits", 32'(rise_cnt - r0), 32'd24);
    chk("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t6_q_empty", 32'(exp_bits.size() + exp_addr.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
